// File: rtl/jelly_bean_arb_pkg.sv
// Shared types and constants for the jelly-bean taster arbiter.
// Optional statistics counters are enabled with JELLY_BEAN_ARB_STATS_EN.
package jelly_bean_arb_pkg;

    localparam int unsigned MAX_RSP_LAT = 15;
    localparam int unsigned CNT_W       = 4;   // holds 1..MAX_RSP_LAT
    localparam int unsigned IDX_W       = 3;   // requester index, up to 8 requesters
    localparam int unsigned STAT_W      = 16;

    typedef enum logic [2:0] {
        NO_FLAVOR        = 3'd0,
        APPLE            = 3'd1,
        BLUEBERRY        = 3'd2,
        BUBBLE_GUM       = 3'd3,
        BUTTERED_POPCORN = 3'd4,
        CHOCOLATE        = 3'd5,
        CINNAMON         = 3'd6,
        COCONUT          = 3'd7
    } flavor_e;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_e;

    typedef enum logic [1:0] {
        NO_OP = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } command_e;

    typedef enum logic [1:0] {
        NO_TASTE = 2'd0,
        YUMMY    = 2'd1,
        YUCKY    = 2'd2
    } taste_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Fields forwarded to the taster for one transaction.
    typedef struct packed {
        flavor_e  flavor;
        color_e   color;
        logic     sugar_free;
        logic     sour;
        command_e command;
    } jb_txn_t;

endpackage

// File: rtl/jelly_bean_rr_picker.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping.
module jelly_bean_rr_picker
    import jelly_bean_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    int unsigned        idx;
    logic [NUM_REQ-1:0] shifted;

    // Scan rr_ptr+1 .. rr_ptr+NUM_REQ (mod NUM_REQ); keep the first hit.
    always_comb begin
        winner  = '0;
        valid   = 1'b0;
        idx     = 0;
        shifted = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            shifted = req >> idx;
            if (!valid && shifted[0]) begin
                valid  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/jelly_bean_taster_arbiter.sv
// Round-robin arbiter sharing one jelly-bean taster among NUM_REQ requesters,
// one transaction in flight. Define JELLY_BEAN_ARB_STATS_EN to add
// saturating yummy/yucky response counters.
module jelly_bean_taster_arbiter
    import jelly_bean_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned RSP_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*3-1:0] req_flavor,
    input  logic [NUM_REQ*2-1:0] req_color,
    input  logic [NUM_REQ-1:0]   req_sugar_free,
    input  logic [NUM_REQ-1:0]   req_sour,
    input  logic [NUM_REQ*2-1:0] req_command,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [1:0]           rsp_taste,
    output logic                 busy,
    output logic [2:0]           jb_flavor,
    output logic [1:0]           jb_color,
    output logic                 jb_sugar_free,
    output logic                 jb_sour,
    output logic [1:0]           jb_command,
    input  logic [1:0]           jb_taste
`ifdef JELLY_BEAN_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]    yummy_cnt,
    output logic [STAT_W-1:0]    yucky_cnt
`endif
);

    arb_state_e         state, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   owner, owner_d;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   cnt, cnt_d;
    jb_txn_t            txn_sel;
    jb_txn_t            jb_q, jb_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [1:0]         rsp_taste_d;
    logic               busy_d;

    jelly_bean_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Mux the winning requester's fields out of the flattened input buses.
    always_comb begin
        txn_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                txn_sel.flavor     = flavor_e'(req_flavor[3*i +: 3]);
                txn_sel.color      = color_e'(req_color[2*i +: 2]);
                txn_sel.sugar_free = req_sugar_free[i];
                txn_sel.sour       = req_sour[i];
                txn_sel.command    = command_e'(req_command[2*i +: 2]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of datapath and outputs; registered below so no input reaches an output combinationally.
    always_comb begin
        rr_ptr_d    = rr_ptr;
        owner_d     = owner;
        cnt_d       = cnt;
        jb_d        = '0;
        rsp_valid_d = '0;
        rsp_taste_d = rsp_taste;
        busy_d      = (state_d != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    owner_d  = pick_idx;
                    rr_ptr_d = pick_idx;
                    jb_d     = txn_sel;
                end
            end
            ISSUE: begin
                cnt_d = CNT_W'(RSP_LAT);
            end
            WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rsp_taste_d = jb_taste;
                    rsp_valid_d = NUM_REQ'(1) << owner;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= IDX_W'(NUM_REQ - 1);
            owner     <= '0;
            cnt       <= '0;
            jb_q      <= '0;
            rsp_valid <= '0;
            rsp_taste <= '0;
            busy      <= 1'b0;
        end else begin
            rr_ptr    <= rr_ptr_d;
            owner     <= owner_d;
            cnt       <= cnt_d;
            jb_q      <= jb_d;
            rsp_valid <= rsp_valid_d;
            rsp_taste <= rsp_taste_d;
            busy      <= busy_d;
        end
    end

    assign jb_flavor     = jb_q.flavor;
    assign jb_color      = jb_q.color;
    assign jb_sugar_free = jb_q.sugar_free;
    assign jb_sour       = jb_q.sour;
    assign jb_command    = jb_q.command;

`ifdef JELLY_BEAN_ARB_STATS_EN
    // Saturating counts of returned tastes, bumped while the response is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            yummy_cnt <= '0;
            yucky_cnt <= '0;
        end else if (state == RESP) begin
            if (rsp_taste == YUMMY && yummy_cnt != {STAT_W{1'b1}}) begin
                yummy_cnt <= yummy_cnt + STAT_W'(1);
            end
            if (rsp_taste == YUCKY && yucky_cnt != {STAT_W{1'b1}}) begin
                yucky_cnt <= yucky_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_jelly_bean_taster_arbiter.sv
// Scoreboard bench for jelly_bean_taster_arbiter: one instance with RSP_LAT=1,
// one with RSP_LAT=3, each driven against a small taster model.
module tb_jelly_bean_taster_arbiter;
    import jelly_bean_arb_pkg::*;

    localparam int unsigned LAT1 = 1;
    localparam int unsigned LAT3 = 3;

    typedef struct {
        int         owner;
        logic [1:0] taste;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q1[$];
    exp_t q3[$];

    // Per-requester fields (r3..r0), shared by both instances.
    logic [11:0] flv  = {3'd7, 3'd3, 3'd6, 3'd5};
    logic [7:0]  col  = {2'd3, 2'd0, 2'd2, 2'd1};
    logic [3:0]  sf   = 4'b1001;
    logic [3:0]  sour = 4'b0000;
    logic [7:0]  cmd  = {2'd0, 2'd2, 2'd2, 2'd1};

    logic [3:0] req1, req3, rsp_valid1, rsp_valid3;
    logic [1:0] rsp_taste1, rsp_taste3, jb_color1, jb_color3, jb_command1, jb_command3;
    logic [1:0] jb_taste1, jb_taste3;
    logic [2:0] jb_flavor1, jb_flavor3;
    logic       busy1, busy3, jb_sf1, jb_sf3, jb_sour1, jb_sour3;
`ifdef JELLY_BEAN_ARB_STATS_EN
    logic [15:0] yummy1, yucky1, yummy3, yucky3;
`endif

    jelly_bean_taster_arbiter #(.NUM_REQ(4), .RSP_LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .req_flavor(flv), .req_color(col),
        .req_sugar_free(sf), .req_sour(sour), .req_command(cmd),
        .rsp_valid(rsp_valid1), .rsp_taste(rsp_taste1), .busy(busy1),
        .jb_flavor(jb_flavor1), .jb_color(jb_color1), .jb_sugar_free(jb_sf1),
        .jb_sour(jb_sour1), .jb_command(jb_command1), .jb_taste(jb_taste1)
`ifdef JELLY_BEAN_ARB_STATS_EN
        , .yummy_cnt(yummy1), .yucky_cnt(yucky1)
`endif
    );

    jelly_bean_taster_arbiter #(.NUM_REQ(4), .RSP_LAT(LAT3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .req_flavor(flv), .req_color(col),
        .req_sugar_free(sf), .req_sour(sour), .req_command(cmd),
        .rsp_valid(rsp_valid3), .rsp_taste(rsp_taste3), .busy(busy3),
        .jb_flavor(jb_flavor3), .jb_color(jb_color3), .jb_sugar_free(jb_sf3),
        .jb_sour(jb_sour3), .jb_command(jb_command3), .jb_taste(jb_taste3)
`ifdef JELLY_BEAN_ARB_STATS_EN
        , .yummy_cnt(yummy3), .yucky_cnt(yucky3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Taster model: odd parity of the sampled fields tastes YUMMY, even YUCKY.
    function automatic logic [1:0] taste_of(input logic [8:0] f);
        return (^f) ? 2'd1 : 2'd2;
    endfunction

    // Hand-derived taste per requester from the field table above.
    function automatic logic [1:0] exp_taste(input int r);
        return (r % 2 == 0) ? 2'd1 : 2'd2;
    endfunction

    // Taster drives its answer only in the RSP_LAT-th cycle after sampling; 2'b11 otherwise.
    logic [3:0] k1, k3;
    logic [1:0] val1, val3;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k1 <= 4'd0; val1 <= 2'd0; k3 <= 4'd0; val3 <= 2'd0;
        end else begin
            if ({jb_flavor1, jb_color1, jb_sf1, jb_sour1, jb_command1} != 9'd0) begin
                k1 <= 4'd1; val1 <= taste_of({jb_flavor1, jb_color1, jb_sf1, jb_sour1, jb_command1});
            end else if (k1 == 4'(LAT1)) k1 <= 4'd0;
            else if (k1 != 4'd0) k1 <= k1 + 4'd1;
            if ({jb_flavor3, jb_color3, jb_sf3, jb_sour3, jb_command3} != 9'd0) begin
                k3 <= 4'd1; val3 <= taste_of({jb_flavor3, jb_color3, jb_sf3, jb_sour3, jb_command3});
            end else if (k3 == 4'(LAT3)) k3 <= 4'd0;
            else if (k3 != 4'd0) k3 <= k3 + 4'd1;
        end
    end
    assign jb_taste1 = (k1 == 4'(LAT1)) ? val1 : 2'b11;
    assign jb_taste3 = (k3 == 4'(LAT3)) ? val3 : 2'b11;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic push(input int d, input int owner, input logic [1:0] taste, input int at);
        exp_t e;
        e.owner = owner; e.taste = taste; e.cyc = at;
        if (d == 1) q1.push_back(e);
        else q3.push_back(e);
    endtask

    task automatic check_rsp(input int d, input logic [3:0] v, input logic [1:0] t);
        exp_t e;
        logic [3:0] ev;
        if ((d == 1 && q1.size() == 0) || (d == 3 && q3.size() == 0)) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp dut%0d actual rsp_valid=%b required none", d, v);
            return;
        end
        if (d == 1) e = q1.pop_front();
        else e = q3.pop_front();
        ev = 4'b0001 << e.owner;
        chk($sformatf("rsp_valid_dut%0d", d), 32'(v), 32'(ev));
        chk($sformatf("rsp_taste_dut%0d_owner%0d", d, e.owner), 32'(t), 32'(e.taste));
        if (e.cyc >= 0) chk($sformatf("rsp_cycle_dut%0d_owner%0d", d, e.owner), cyc, e.cyc);
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk) begin
        if (rsp_valid1 != 4'd0) check_rsp(1, rsp_valid1, rsp_taste1);
        if (rsp_valid3 != 4'd0) check_rsp(3, rsp_valid3, rsp_taste3);
    end

    int         c;
    int         wr_cnt;
    logic [2:0] wr_flv;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; req1 = 4'd0; req3 = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy1), 32'd0);
        chk("reset_jb_command", 32'(jb_command1), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("reset_rsp_taste", 32'(rsp_taste1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single WRITE from requester 2 (flavor 3), expect YUMMY at t+3.
        c = cyc; push(1, 2, 2'd1, c + 3); req1 = 4'b0100;
        wr_cnt = 0; wr_flv = 3'd0;
        repeat (3) begin
            @(negedge clk);
            if (jb_command1 == 2'd2) begin wr_cnt++; wr_flv = jb_flavor1; end
        end
        req1 = 4'd0;
        repeat (3) begin
            @(negedge clk);
            if (jb_command1 == 2'd2) wr_cnt++;
        end
        chk("t1_write_cycles", 32'(wr_cnt), 32'd1);
        chk("t1_jb_flavor", 32'(wr_flv), 32'd3);

        // Requester 1 alone moves rr_ptr to 1.
        c = cyc; push(1, 1, exp_taste(1), c + 3); req1 = 4'b0010;
        repeat (3) @(negedge clk);
        req1 = 4'd0;
        repeat (2) @(negedge clk);

        // rr_ptr=1, req=1001 held: 3, 0, 3, 0; req dropped mid-transaction of the last.
        c = cyc;
        push(1, 3, exp_taste(3), c + 3);
        push(1, 0, exp_taste(0), c + 7);
        push(1, 3, exp_taste(3), c + 11);
        push(1, 0, exp_taste(0), c + 15);
        req1 = 4'b1001;
        repeat (14) @(negedge clk);
        req1 = 4'd0;
        repeat (4) @(negedge clk);
`ifdef JELLY_BEAN_ARB_STATS_EN
        chk("stats_yummy_pre", 32'(yummy1), 32'd3);
        chk("stats_yucky_pre", 32'(yucky1), 32'd3);
`endif

        // Reset during WAIT drops the transaction immediately.
        req1 = 4'b0001;
        repeat (2) @(negedge clk);
        chk("rst_pre_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_jb_command", 32'(jb_command1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        req1 = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
`ifdef JELLY_BEAN_ARB_STATS_EN
        chk("stats_cleared", 32'(yummy1), 32'd0);
`endif

        // All four held after reset: grants 0,1,2,3,0, one response every 4 cycles.
        c = cyc;
        for (int k = 0; k < 5; k++) push(1, k % 4, exp_taste(k % 4), c + 3 + 4 * k);
        req1 = 4'b1111;
        repeat (18) @(negedge clk);
        req1 = 4'd0;
        repeat (4) @(negedge clk);
`ifdef JELLY_BEAN_ARB_STATS_EN
        chk("stats_yummy", 32'(yummy1), 32'd3);
        chk("stats_yucky", 32'(yucky1), 32'd2);
`endif

        // RSP_LAT=3: taste present only in the 3rd cycle after sampling, response at t+5.
        c = cyc; push(3, 1, 2'd2, c + 5); req3 = 4'b0010;
        repeat (5) @(negedge clk);
        req3 = 4'd0;
        repeat (2) @(negedge clk);
        c = cyc; push(3, 0, 2'd1, c + 5); req3 = 4'b0001;
        repeat (5) @(negedge clk);
        req3 = 4'd0;
        repeat (3) @(negedge clk);

        chk("missing_rsp_dut1", 32'(q1.size()), 32'd0);
        chk("missing_rsp_dut3", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
